// File: rtl/keypad_scan_entry.sv
// ---------------------------------------------------------------------------
// keypad_scan_entry
//
// Scans a 4x4 active-low matrix keypad one column at a time, debounces a
// single key over whole scan frames, decodes it, and turns accepted keys
// into a decimal entry of up to four digits. The enter key commits the
// working value so a display driver can show it.
//
// Parameters:
//   SCAN_DIV       clock cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS identical frames needed to accept a press or release (1..15)
//
// Ports:
//   clock_100Mhz     in   system clock
//   reset            in   synchronous, active-high reset
//   row_in[3:0]      in   keypad rows, active-low, asynchronous
//   col_out[3:0]     out  keypad columns, active-low, one low at a time
//   key_valid        out  one-cycle pulse on an accepted press
//   key_code[3:0]    out  code of the last accepted key
//   entry_value[13:0]     working value being typed (0..9999)
//   digit_count[2:0]      digits held in entry_value (0..4)
//   committed_value[13:0] value latched by the enter key
//   enter_pulse      out  one-cycle pulse when a commit happens
// ---------------------------------------------------------------------------
module keypad_scan_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [13:0] entry_value,
    output logic [2:0]  digit_count,
    output logic [13:0] committed_value,
    output logic        enter_pulse
);

    localparam int              DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Decode a (row, column) intersection into the key code.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            4'hF: code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Number of asserted bits in a 4-bit vector.
    function automatic logic [2:0] count_ones(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest asserted bit (only meaningful when exactly one is set).
    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       col_r;
    logic [3:0]       col_out_r;
    logic [1:0]       acc_hits_r;   // 0 = none, 1 = single, 2 = multiple so far this frame
    logic [3:0]       acc_code_r;
    state_t           state_r;
    logic [3:0]       cand_r;
    logic [3:0]       cnt_r;
    logic             key_valid_r;
    logic [3:0]       key_code_r;
    logic [13:0]      entry_value_r;
    logic [2:0]       digit_count_r;
    logic [13:0]      committed_value_r;
    logic             enter_pulse_r;

    logic       sample_s;
    logic       frame_end_s;
    logic [1:0] col_next_s;
    logic [3:0] col_low_s;
    logic [2:0] col_hits_s;
    logic [3:0] col_code_s;
    logic [1:0] merged_hits_s;
    logic [3:0] merged_code_s;
    logic       frame_none_s;
    logic       frame_single_s;
    state_t     state_n;
    logic [3:0] cand_n;
    logic [3:0] cnt_n;
    logic [3:0] cnt_inc_s;
    logic       accept_s;

    // Two-flop synchronizer for the asynchronous row inputs (idle rows read high).
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Column divider and active-low column drive.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            div_r     <= '0;
            col_r     <= 2'd0;
            col_out_r <= 4'b1110;
        end else if (div_r == DIV_LAST) begin
            div_r     <= '0;
            col_r     <= col_next_s;
            col_out_r <= ~(4'b0001 << col_next_s);
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Per-column sampling and merge into a running frame classification.
    always_comb begin
        sample_s      = (div_r == DIV_LAST);
        frame_end_s   = sample_s && (col_r == 2'd3);
        col_next_s    = col_r + 2'd1;
        col_low_s     = ~row_sync_r;
        col_hits_s    = count_ones(col_low_s);
        col_code_s    = key_lookup(first_set(col_low_s), col_r);
        merged_hits_s = acc_hits_r;
        merged_code_s = acc_code_r;
        if (acc_hits_r == 2'd0) begin
            merged_hits_s = (col_hits_s >= 3'd2) ? 2'd2 : col_hits_s[1:0];
            merged_code_s = col_code_s;
        end else if (acc_hits_r == 2'd1) begin
            merged_hits_s = (col_hits_s == 3'd0) ? 2'd1 : 2'd2;
            merged_code_s = acc_code_r;
        end else begin
            merged_hits_s = 2'd2;
            merged_code_s = acc_code_r;
        end
        frame_none_s   = (merged_hits_s == 2'd0);
        frame_single_s = (merged_hits_s == 2'd1);
    end

    // Frame accumulator: cleared at the end of column 3 after being consumed.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= 4'd0;
        end else if (frame_end_s) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= 4'd0;
        end else if (sample_s) begin
            acc_hits_r <= merged_hits_s;
            acc_code_r <= merged_code_s;
        end else begin
            acc_hits_r <= acc_hits_r;
            acc_code_r <= acc_code_r;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_r <= IDLE;
            cand_r  <= 4'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_n;
            cand_r  <= cand_n;
            cnt_r   <= cnt_n;
        end
    end

    // Debounce FSM next state; MULTI frames count as neither single nor none.
    always_comb begin
        state_n   = state_r;
        cand_n    = cand_r;
        cnt_n     = cnt_r;
        accept_s  = 1'b0;
        cnt_inc_s = cnt_r + 4'd1;
        if (frame_end_s) begin
            case (state_r)
                IDLE: begin
                    if (frame_single_s) begin
                        cand_n = merged_code_s;
                        cnt_n  = 4'd1;
                        if (DB_TARGET <= 4'd1) begin
                            state_n  = HELD;
                            accept_s = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if (frame_single_s && (merged_code_s == cand_r)) begin
                        cnt_n = cnt_inc_s;
                        if (cnt_inc_s >= DB_TARGET) begin
                            state_n  = HELD;
                            accept_s = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else if (frame_single_s) begin
                        cand_n  = merged_code_s;
                        cnt_n   = 4'd1;
                        state_n = DEBOUNCE;
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (frame_none_s) begin
                        cnt_n   = 4'd1;
                        state_n = (DB_TARGET <= 4'd1) ? IDLE : RELEASE;
                    end else begin
                        state_n = HELD;
                    end
                end
                RELEASE: begin
                    if (frame_none_s) begin
                        cnt_n   = cnt_inc_s;
                        state_n = (cnt_inc_s >= DB_TARGET) ? IDLE : RELEASE;
                    end else begin
                        state_n = HELD;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Accepted-key actions: digit entry, backspace, clear and commit.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            key_valid_r       <= 1'b0;
            key_code_r        <= 4'd0;
            entry_value_r     <= 14'd0;
            digit_count_r     <= 3'd0;
            committed_value_r <= 14'd0;
            enter_pulse_r     <= 1'b0;
        end else begin
            key_valid_r   <= accept_s;
            enter_pulse_r <= 1'b0;
            if (accept_s) begin
                key_code_r <= merged_code_s;
                case (merged_code_s)
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                    4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                        if (digit_count_r < 3'd4) begin
                            entry_value_r <= entry_value_r * 14'd10 + {10'd0, merged_code_s};
                            digit_count_r <= digit_count_r + 3'd1;
                        end
                    end
                    4'd12: begin
                        if (digit_count_r > 3'd0) begin
                            entry_value_r <= entry_value_r / 14'd10;
                            digit_count_r <= digit_count_r - 3'd1;
                        end
                    end
                    4'd14: begin
                        entry_value_r <= 14'd0;
                        digit_count_r <= 3'd0;
                    end
                    4'd15: begin
                        committed_value_r <= entry_value_r;
                        enter_pulse_r     <= 1'b1;
                        entry_value_r     <= 14'd0;
                        digit_count_r     <= 3'd0;
                    end
                    default: begin
                        entry_value_r <= entry_value_r;
                    end
                endcase
            end
        end
    end

    assign col_out         = col_out_r;
    assign key_valid       = key_valid_r;
    assign key_code        = key_code_r;
    assign entry_value     = entry_value_r;
    assign digit_count     = digit_count_r;
    assign committed_value = committed_value_r;
    assign enter_pulse     = enter_pulse_r;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_entry
//
// Directed bench for keypad_scan_entry with SCAN_DIV = 8 and
// DEBOUNCE_SCANS = 2 (32-cycle frames). A small keypad model pulls a row
// low whenever a pressed key sits in the column currently driven low.
// ---------------------------------------------------------------------------
module tb_keypad_scan_entry;

    localparam int SD    = 8;
    localparam int DB    = 2;
    localparam int FRAME = 4 * SD;

    logic        clock_100Mhz = 1'b0;
    logic        reset        = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] entry_value;
    logic [2:0]  digit_count;
    logic [13:0] committed_value;
    logic        enter_pulse;

    logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c
    int vectors     = 0;
    int miscompares = 0;
    int kv_cnt      = 0;
    int ep_cnt      = 0;

    keypad_scan_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clock_100Mhz    (clock_100Mhz),
        .reset           (reset),
        .row_in          (row_in),
        .col_out         (col_out),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .entry_value     (entry_value),
        .digit_count     (digit_count),
        .committed_value (committed_value),
        .enter_pulse     (enter_pulse)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    // Keypad matrix model.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] key_mask(input int code);
        case (code)
            1:  return 16'h0001;
            2:  return 16'h0002;
            3:  return 16'h0004;
            10: return 16'h0008;
            4:  return 16'h0010;
            5:  return 16'h0020;
            6:  return 16'h0040;
            11: return 16'h0080;
            7:  return 16'h0100;
            8:  return 16'h0200;
            9:  return 16'h0400;
            12: return 16'h0800;
            14: return 16'h1000;
            0:  return 16'h2000;
            15: return 16'h4000;
            13: return 16'h8000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock_100Mhz);
        #1;
        if (key_valid === 1'b1) kv_cnt++;
        if (enter_pulse === 1'b1) ep_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int code, input int hold_frames, input int rel_frames);
        pressed = key_mask(code);
        run(hold_frames * FRAME);
        pressed = 16'h0000;
        run(rel_frames * FRAME);
    endtask

    initial begin
        // 1. reset values and idle column scan
        reset = 1'b1;
        run(3);
        check("rst_col",   {28'd0, col_out}, 32'd14);
        check("rst_kv",    {31'd0, key_valid}, 32'd0);
        check("rst_code",  {28'd0, key_code}, 32'd0);
        check("rst_entry", {18'd0, entry_value}, 32'd0);
        check("rst_digits",{29'd0, digit_count}, 32'd0);
        check("rst_commit",{18'd0, committed_value}, 32'd0);
        check("rst_enter", {31'd0, enter_pulse}, 32'd0);
        reset = 1'b0;
        run(7);
        check("col0_end",  {28'd0, col_out}, 32'hE);
        run(1);
        check("col1",      {28'd0, col_out}, 32'hD);
        run(8);
        check("col2",      {28'd0, col_out}, 32'hB);
        run(8);
        check("col3",      {28'd0, col_out}, 32'h7);
        run(8);
        check("col_wrap",  {28'd0, col_out}, 32'hE);
        run(3 * FRAME);
        check("idle_kv",    kv_cnt, 32'd0);
        check("idle_entry", {18'd0, entry_value}, 32'd0);

        // 2. digits 1..5, fifth ignored by the 4-digit cap
        for (int k = 1; k <= 5; k++) begin
            press(k, 5, 5);
            check("digit_kv",   kv_cnt, 32'(k));
            check("digit_code", {28'd0, key_code}, 32'(k));
        end
        check("entry_1234", {18'd0, entry_value}, 32'd1234);
        check("digits_cap", {29'd0, digit_count}, 32'd4);

        // 3. enter commits
        press(15, 5, 5);
        check("enter_cnt",    ep_cnt, 32'd1);
        check("commit_1234",  {18'd0, committed_value}, 32'd1234);
        check("enter_entry",  {18'd0, entry_value}, 32'd0);
        check("enter_digits", {29'd0, digit_count}, 32'd0);
        check("enter_kv",     kv_cnt, 32'd6);

        // 4. bouncing key 7, then steady hold without auto-repeat
        for (int f = 0; f < 4; f++) begin
            pressed = key_mask(7);
            run(FRAME);
            pressed = 16'h0000;
            run(FRAME);
        end
        check("bounce_kv", kv_cnt, 32'd6);
        pressed = key_mask(7);
        run(5 * FRAME);
        check("hold7_kv", kv_cnt, 32'd7);
        run(15 * FRAME);
        check("no_repeat", kv_cnt, 32'd7);
        check("entry_7",   {18'd0, entry_value}, 32'd7);
        pressed = 16'h0000;
        run(5 * FRAME);

        // 5. two keys together, then only key 1
        pressed = key_mask(1) | key_mask(5);
        run(4 * FRAME);
        check("multi_kv", kv_cnt, 32'd7);
        pressed = key_mask(1);
        run(5 * FRAME);
        check("after_multi_kv",   kv_cnt, 32'd8);
        check("after_multi_code", {28'd0, key_code}, 32'd1);
        pressed = 16'h0000;
        run(5 * FRAME);
        check("entry_71", {18'd0, entry_value}, 32'd71);
        press(14, 5, 5);
        check("clear_entry",  {18'd0, entry_value}, 32'd0);
        check("clear_digits", {29'd0, digit_count}, 32'd0);
        press(9, 5, 5);
        press(8, 5, 5);
        check("entry_98", {18'd0, entry_value}, 32'd98);
        press(12, 5, 5);
        check("bs_9", {18'd0, entry_value}, 32'd9);
        press(12, 5, 5);
        check("bs_0", {18'd0, entry_value}, 32'd0);
        press(12, 5, 5);
        check("bs_empty",   {18'd0, entry_value}, 32'd0);
        check("bs_digits",  {29'd0, digit_count}, 32'd0);
        check("bs_kv",      kv_cnt, 32'd14);
        check("bs_code",    {28'd0, key_code}, 32'd12);
        check("commit_kept",{18'd0, committed_value}, 32'd1234);

        // 6. reset while key 3 is held, then re-acceptance after two frames
        pressed = key_mask(3);
        run(5 * FRAME);
        check("held3_kv",    kv_cnt, 32'd15);
        check("held3_entry", {18'd0, entry_value}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_col",    {28'd0, col_out}, 32'd14);
        check("mid_rst_code",   {28'd0, key_code}, 32'd0);
        check("mid_rst_entry",  {18'd0, entry_value}, 32'd0);
        check("mid_rst_digits", {29'd0, digit_count}, 32'd0);
        check("mid_rst_commit", {18'd0, committed_value}, 32'd0);
        check("mid_rst_kv",     {31'd0, key_valid}, 32'd0);
        run(2 * FRAME - 1);
        check("reaccept_early", kv_cnt, 32'd15);
        tick();
        check("reaccept_pulse", {31'd0, key_valid}, 32'd1);
        tick();
        check("pulse_one_cycle", {31'd0, key_valid}, 32'd0);
        check("reaccept_kv",     kv_cnt, 32'd16);
        check("reaccept_entry",  {18'd0, entry_value}, 32'd3);
        check("reaccept_digits", {29'd0, digit_count}, 32'd1);
        check("reaccept_code",   {28'd0, key_code}, 32'd3);
        check("enter_total",     ep_cnt, 32'd1);
        pressed = 16'h0000;
        run(5 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
